// File: rtl/mp_core.sv
// mp_core: multicycle 16-bit-instruction core with a FETCH/EXEC/WB/HALT FSM,
// a wait-state tolerant fetch port, an 8 x DW register file and carry/zero flags.
module mp_core #(
    parameter int unsigned DW  = 8,
    parameter int unsigned PCW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_valid,
    input  logic [15:0]    imem_rdata,
    output logic [15:0]    ir_data,
    output logic [PCW-1:0] pc,
    output logic           cy,
    output logic           zero,
    output logic           halted,
    output logic           wb_en,
    output logic [2:0]     wb_addr,
    output logic [DW-1:0]  wb_data
);

    typedef enum logic [1:0] {StFetch, StExec, StWb, StHalt} state_e;

    state_e         r_state;
    state_e         w_state_next;

    // Architectural state
    logic [15:0]    r_ir;
    logic [PCW-1:0] r_pc;
    logic           r_cy;
    logic           r_zero;
    logic [DW-1:0]  r_rf [8];

    // EXEC -> WB pipeline registers
    logic [DW-1:0]  r_res;
    logic           r_res_cy;
    logic           r_res_zero;
    logic           r_flag_we;
    logic           r_rf_we;
    logic [2:0]     r_wb_addr;
    logic [PCW-1:0] r_pc_next;

    // Decode
    logic [3:0]     w_op;
    logic [2:0]     w_rd;
    logic [2:0]     w_rs1;
    logic [2:0]     w_rs2;
    logic [7:0]     w_imm;
    logic [DW-1:0]  w_a;
    logic [DW-1:0]  w_b;

    // Execute
    logic [DW:0]    w_sum;
    logic [DW-1:0]  w_alu_res;
    logic           w_alu_cy;
    logic           w_is_alu;
    logic           w_is_wr;
    logic           w_taken;
    logic [PCW-1:0] w_pc_seq;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:9];
    assign w_rs1 = r_ir[8:6];
    assign w_rs2 = r_ir[5:3];
    assign w_imm = r_ir[7:0];
    assign w_a   = r_rf[w_rs1];
    assign w_b   = r_rf[w_rs2];

    // Wraps modulo 2^PCW naturally
    assign w_pc_seq = r_pc + PCW'(1);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; HALT is only left through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch: if (imem_valid) w_state_next = StExec;
            StExec:  w_state_next = (w_op == 4'hF) ? StHalt : StWb;
            StWb:    w_state_next = StFetch;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StFetch;
        endcase
    end

    // FSM outputs; the request is held low while reset is asserted
    always_comb begin
        imem_req = 1'b0;
        halted   = 1'b0;
        wb_en    = 1'b0;
        case (r_state)
            StFetch: imem_req = rst_n;
            StWb:    wb_en    = r_rf_we;
            StHalt:  halted   = 1'b1;
            default: ;
        endcase
    end

    // ALU and instruction class decode
    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_alu_cy  = 1'b0;
        w_is_alu  = 1'b0;
        w_is_wr   = 1'b0;
        w_taken   = 1'b0;
        case (w_op)
            4'h1: begin
                w_sum     = {1'b0, w_a} + {1'b0, w_b};
                w_alu_res = w_sum[DW-1:0];
                w_alu_cy  = w_sum[DW];
                w_is_alu  = 1'b1;
            end
            4'h2: begin
                // Borrow appears in the extra bit when rs1 < rs2
                w_sum     = {1'b0, w_a} - {1'b0, w_b};
                w_alu_res = w_sum[DW-1:0];
                w_alu_cy  = w_sum[DW];
                w_is_alu  = 1'b1;
            end
            4'h3: begin
                w_alu_res = w_a & w_b;
                w_is_alu  = 1'b1;
            end
            4'h4: begin
                w_alu_res = w_a | w_b;
                w_is_alu  = 1'b1;
            end
            4'h5: begin
                w_alu_res = w_a ^ w_b;
                w_is_alu  = 1'b1;
            end
            4'h6: begin
                w_alu_res = w_a << 1;
                w_alu_cy  = w_a[DW-1];
                w_is_alu  = 1'b1;
            end
            4'h7: begin
                w_alu_res = w_a >> 1;
                w_alu_cy  = w_a[0];
                w_is_alu  = 1'b1;
            end
            4'h8: w_alu_res = DW'(w_imm);
            4'h9: w_taken   = 1'b1;
            4'hA: w_taken   = r_zero;
            4'hB: w_taken   = r_cy;
            default: ;
        endcase
        w_is_wr = w_is_alu | (w_op == 4'h8);
    end

    // Instruction register, loaded only on an accepted fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (r_state == StFetch && imem_valid) begin
            r_ir <= imem_rdata;
        end
    end

    // EXEC captures the results; nothing architectural changes until WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res      <= '0;
            r_res_cy   <= 1'b0;
            r_res_zero <= 1'b0;
            r_flag_we  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_pc_next  <= '0;
        end else if (r_state == StExec) begin
            r_res      <= w_alu_res;
            r_res_cy   <= w_alu_cy;
            r_res_zero <= (w_alu_res == '0);
            r_flag_we  <= w_is_alu;
            r_rf_we    <= w_is_wr;
            r_wb_addr  <= w_rd;
            r_pc_next  <= w_taken ? w_imm[PCW-1:0] : w_pc_seq;
        end
    end

    // WB commits pc and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_cy   <= 1'b0;
            r_zero <= 1'b0;
        end else if (r_state == StWb) begin
            r_pc <= r_pc_next;
            if (r_flag_we) begin
                r_cy   <= r_res_cy;
                r_zero <= r_res_zero;
            end
        end
    end

    // Register file write port, active only in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_state == StWb && r_rf_we) begin
            r_rf[r_wb_addr] <= r_res;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir_data   = r_ir;
    assign cy        = r_cy;
    assign zero      = r_zero;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_res;

endmodule

// File: tb/tb_mp_core.sv
// Bench for mp_core: table of ALU vectors, directed multi-cycle sequences and
// random programs checked against an instruction-level model.
module tb_mp_core;

    localparam int DW  = 8;
    localparam int PCW = 8;
    localparam int MSZ = 1 << DW;
    localparam int PSZ = 1 << PCW;

    logic           clk;
    logic           rst_n;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_valid;
    logic [15:0]    imem_rdata;
    logic [15:0]    ir_data;
    logic [PCW-1:0] pc;
    logic           cy;
    logic           zero;
    logic           halted;
    logic           wb_en;
    logic [2:0]     wb_addr;
    logic [DW-1:0]  wb_data;

    // Second instance with a 4-bit pc for wrap and halt checks
    logic           rst4_n;
    logic           imem_req_4;
    logic [3:0]     imem_addr_4;
    logic           imem_valid_4;
    logic [15:0]    imem_rdata_4;
    logic [15:0]    ir_data_4;
    logic [3:0]     pc_4;
    logic           cy_4;
    logic           zero_4;
    logic           halted_4;
    logic           wb_en_4;
    logic [2:0]     wb_addr_4;
    logic [7:0]     wb_data_4;

    mp_core #(.DW(DW), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .ir_data(ir_data), .pc(pc), .cy(cy), .zero(zero), .halted(halted),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    mp_core #(.DW(8), .PCW(4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .imem_req(imem_req_4), .imem_addr(imem_addr_4),
        .imem_valid(imem_valid_4), .imem_rdata(imem_rdata_4),
        .ir_data(ir_data_4), .pc(pc_4), .cy(cy_4), .zero(zero_4), .halted(halted_4),
        .wb_en(wb_en_4), .wb_addr(wb_addr_4), .wb_data(wb_data_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories and wait-state generator
    logic [15:0] mem  [256];
    logic [15:0] mem4 [16];
    int  wait_n;
    int  rnd_wait;
    int  cur_wait;
    int  wcnt;
    int  cyc;
    bit  rnd_mode;
    bit  noise;

    assign cur_wait     = rnd_mode ? rnd_wait : wait_n;
    // Outside FETCH the valid line carries noise the core must ignore
    assign imem_valid   = imem_req ? (wcnt >= cur_wait) : noise;
    assign imem_rdata   = mem[imem_addr];
    assign imem_valid_4 = imem_req_4;
    assign imem_rdata_4 = mem4[imem_addr_4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= 1'($urandom_range(0, 1));
        if (imem_req && imem_valid) rnd_wait <= int'($urandom_range(0, 3));
    end

    // Scoreboard counters
    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Instruction-level reference model
    int m_rf [8];
    int m_pc;
    bit m_cy;
    bit m_z;
    bit m_halt;
    bit exp_we;
    int exp_wa;
    int exp_wd;
    int last_wd;
    int wb_cycs[$];
    int acc_cycs[$];
    int fetch_hist[$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        m_pc = 0; m_cy = 0; m_z = 0; m_halt = 0;
        wb_cycs.delete(); acc_cycs.delete(); fetch_hist.delete();
    endtask

    task automatic model_step(input logic [15:0] instr);
        int op, rd, a, b, imm, res, npc;
        bit c, upd;
        op  = int'(instr[15:12]);
        rd  = int'(instr[11:9]);
        a   = m_rf[instr[8:6]];
        b   = m_rf[instr[5:3]];
        imm = int'(instr[7:0]);
        res = 0; c = 0; upd = 0; exp_we = 0;
        npc = (m_pc + 1) % PSZ;
        case (op)
            1: begin res = (a + b) % MSZ; c = (a + b) >= MSZ; upd = 1; end
            2: begin res = (a - b + MSZ) % MSZ; c = a < b; upd = 1; end
            3: begin res = a & b; upd = 1; end
            4: begin res = a | b; upd = 1; end
            5: begin res = a ^ b; upd = 1; end
            6: begin res = (a * 2) % MSZ; c = a >= MSZ / 2; upd = 1; end
            7: begin res = a / 2; c = (a % 2) == 1; upd = 1; end
            8: res = imm % MSZ;
            9: npc = imm % PSZ;
            10: if (m_z) npc = imm % PSZ;
            11: if (m_cy) npc = imm % PSZ;
            default: ;
        endcase
        if (op >= 1 && op <= 8) begin
            exp_we = 1; exp_wa = rd; exp_wd = res; m_rf[rd] = res;
        end
        if (upd) begin
            m_cy = c; m_z = (res == 0);
        end
        if (op == 15) m_halt = 1;
        else m_pc = npc;
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        logic [31:0] o, d, s1, s2;
        o = op; d = rd; s1 = rs1; s2 = rs2;
        return {o[3:0], d[2:0], s1[2:0], s2[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] enci(input int op, input int rd, input int imm);
        logic [31:0] o, d, im;
        o = op; d = rd; im = imm;
        return {o[3:0], d[2:0], 1'b0, im[7:0]};
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_ir"}, ir_data, 0);
        chk({tag, "_cy"}, cy, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_wb_en"}, wb_en, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    // Runs one instruction in lockstep with the model; returns in the next FETCH
    task automatic exec_one();
        int n;
        logic [15:0] instr;
        n = 0;
        while (!(imem_req && imem_valid)) begin
            if (imem_req) chk("addr_stable", imem_addr, m_pc);
            @(negedge clk);
            n++;
            if (n > 100) begin
                fail_now("fetch_wait");
                return;
            end
        end
        chk("fetch_addr", imem_addr, m_pc);
        acc_cycs.push_back(cyc);
        fetch_hist.push_back(m_pc);
        instr = mem[m_pc];
        model_step(instr);
        @(negedge clk);
        chk("exec_ir", ir_data, instr);
        chk("exec_req", imem_req, 0);
        @(negedge clk);
        if (m_halt) begin
            chk("halt_flag", halted, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_pc", pc, m_pc);
        end else begin
            chk("wb_en", wb_en, exp_we);
            if (exp_we) begin
                chk("wb_addr", wb_addr, exp_wa);
                chk("wb_data", wb_data, exp_wd);
                last_wd = int'(wb_data);
                wb_cycs.push_back(cyc);
            end
            @(negedge clk);
            chk("pc", pc, m_pc);
            chk("cy", cy, m_cy);
            chk("zero", zero, m_z);
        end
    endtask

    task automatic run_until_halt(input int max_instr);
        for (int i = 0; i < max_instr; i++) begin
            if (m_halt) break;
            exec_one();
        end
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cy;
        logic       z;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int waits [2];
        checks = 0; errors = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        wait_n = 0; rnd_mode = 0;
        fill_mem(16'hF000);
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;

        vecs[0] = '{4'h1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{4'h1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{4'h2, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[3] = '{4'h2, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{4'h3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{4'h4, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0};
        vecs[6] = '{4'h5, 8'hF0, 8'hF0, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{4'h6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
        vecs[8] = '{4'h7, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
        waits[0] = 0;
        waits[1] = 4;

        // ALU vectors, zero-wait and with 4 wait states per fetch
        for (int w = 0; w < 2; w++) begin
            wait_n = waits[w];
            for (int v = 0; v < 9; v++) begin
                fill_mem(16'hF000);
                mem[0] = enci(8, 1, int'(vecs[v].a));
                mem[1] = enci(8, 2, int'(vecs[v].b));
                mem[2] = enc(int'(vecs[v].op), 3, 1, 2);
                do_reset();
                exec_one(); exec_one(); exec_one();
                chk("vec_res", last_wd, vecs[v].res);
                chk("vec_cy", cy, vecs[v].cy);
                chk("vec_zero", zero, vecs[v].z);
                if (v == 0) begin
                    if (wb_cycs.size() == 3 && acc_cycs.size() == 3) begin
                        chk("wb_gap1", wb_cycs[1] - wb_cycs[0], 3 + waits[w]);
                        chk("wb_gap2", wb_cycs[2] - wb_cycs[1], 3 + waits[w]);
                        chk("instr_cycles", acc_cycs[2] - acc_cycs[1], 3 + waits[w]);
                    end else begin
                        fail_now("wb_count");
                    end
                end
                exec_one();
            end
        end
        wait_n = 0;

        // Subtract to zero, then JZ taken
        fill_mem(16'hF000);
        mem[0] = enci(8, 1, 5);
        mem[1] = enc(2, 2, 1, 1);
        mem[2] = enci(10, 0, 16'h10);
        do_reset();
        exec_one(); exec_one();
        chk("sub_res", last_wd, 0);
        chk("sub_zero", zero, 1);
        chk("sub_cy", cy, 0);
        exec_one();
        chk("jz_target", imem_addr, 8'h10);
        exec_one();

        // Counted loop: three decrements of r1 before JZ exits
        fill_mem(16'hF000);
        mem[0] = enci(8, 1, 3);
        mem[1] = enci(8, 2, 1);
        mem[2] = enci(8, 3, 0);
        mem[3] = enc(1, 3, 3, 2);
        mem[4] = enc(2, 1, 1, 2);
        mem[5] = enci(10, 0, 7);
        mem[6] = enci(9, 0, 3);
        do_reset();
        run_until_halt(40);
        n = 0;
        foreach (fetch_hist[i]) if (fetch_hist[i] == 3) n++;
        chk("loop_iters", n, 3);
        chk("loop_halted", halted, 1);
        chk("loop_pc", pc, 7);

        // Reset dropped during the EXEC of an ADD
        fill_mem(16'hF000);
        mem[0] = enci(8, 1, 5);
        mem[1] = enci(8, 2, 7);
        mem[2] = enc(1, 3, 1, 2);
        do_reset();
        exec_one(); exec_one();
        n = 0;
        while (!(imem_req && imem_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fetch_addr", imem_addr, 2);
        @(negedge clk);
        chk("mid_exec_ir", ir_data, mem[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid");
        @(negedge clk);
        chk("mid_wb_en", wb_en, 0);
        model_reset();
        rst_n = 1'b1;
        #1;
        run_until_halt(10);
        chk("mid_rerun_res", last_wd, 12);

        // Random programs with random wait states
        rnd_mode = 1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            end
            do_reset();
            run_until_halt(250);
        end
        rnd_mode = 0;

        // PCW=4: NOP stream wraps 15 -> 0, then halts at 6
        @(negedge clk);
        rst4_n = 1'b1;
        #1;
        for (int i = 0; i < 18; i++) begin
            n = 0;
            while (!imem_req_4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!imem_req_4) fail_now("wrap_fetch");
            else chk("wrap_addr", imem_addr_4, i % 16);
            @(negedge clk);
        end
        mem4[6] = 16'hF000;
        n = 0;
        while (!halted_4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!halted_4) fail_now("halt_wait");
        for (int i = 0; i < 20; i++) begin
            chk("hold_halted", halted_4, 1);
            chk("hold_req", imem_req_4, 0);
            chk("hold_pc", pc_4, 6);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_core.md
# mp_core

Parametrised multicycle successor to the single-cycle `mp` top. It fetches 16-bit instructions from an external instruction memory over a valid handshake, decodes them, executes them on a DW-bit ALU with carry and zero flags, and writes the result to an 8-entry register file. It adds the following behaviour:
- a registered FSM;
- wait-state tolerant fetch;
- conditional and unconditional branches;
- load-immediate;
- halt.

## Interface
Parameters:
- `DW`, 8, datapath and register width (4..16).
- `PCW`, 8, program counter width (4..8).

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, high only in FETCH.
- `imem_addr`  out  PCW  fetch address, equals `pc`.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle. Sampled only in FETCH.
- `imem_rdata`  in  16  instruction word.
- `ir_data`  out  16  current instruction register.
- `pc`  out  PCW  program counter.
- `cy`  out  1  carry flag.
- `zero`  out  1  zero flag.
- `halted`  out  1  core is in HALT.
- `wb_en`  out  1  register write strobe, one cycle, in WB.
- `wb_addr`  out  3  register being written.
- `wb_data`  out  DW  value being written.

## Operation
Instruction format:
- `[15:12]` opcode.
- `[11:9]` rd.
- `[8:6]` rs1.
- `[5:3]` rs2.
- `[7:0]` imm.

Opcodes:
- 0 NOP.
- 1 ADD: `rd = rs1 + rs2`, `cy` = carry-out.
- 2 SUB: `rd = rs1 - rs2`, `cy` = borrow (`rs1 < rs2`, unsigned).
- 3 AND, 4 OR, 5 XOR: `cy` = 0.
- 6 SHL: `rd = rs1 << 1`, `cy` = old MSB.
- 7 SHR: `rd = rs1 >> 1` (logical), `cy` = old LSB.
- 8 LDI: `rd = imm`, zero-extended or truncated to DW. Flags unchanged.
- 9 JMP: `pc = imm[PCW-1:0]`.
- A JZ: jump if `zero`.
- B JC: jump if `cy`.
- F HLT.
- C, D, E: behave as NOP.

Flag rules:
- Opcodes 1–7 update both flags.
- `zero` = (DW-bit result == 0).
- No other opcode touches the flags.

Registers:
- 8 × DW.
- Two combinational read ports, one write port, written only in WB.
- r0 is an ordinary register.

FSM states:
- FETCH:
  - `imem_req` = 1.
  - If `imem_valid`, load `ir_data` from `imem_rdata` and go to EXEC.
  - Otherwise stay, with `ir_data` held.
- EXEC:
  - Read rs1/rs2.
  - Register the ALU result, the new flags and the next pc into pipeline registers.
  - Go to WB, or to HALT for HLT.
- WB:
  - Commit the register write for opcodes 1–8 (`wb_en` = 1).
  - Commit the flags and `pc`.
  - Go to FETCH.
- HALT:
  - `imem_req` = 0 and `halted` = 1.
  - Left only by reset.

Next pc:
- Taken branch: `imm[PCW-1:0]`.
- Otherwise: `pc + 1`, wrapping modulo 2^PCW (PC at 2^PCW−1 goes to 0).
- Branch conditions use the flags as they stand at EXEC, i.e. the flags committed by the previous instruction.

HLT:
- `pc` is not advanced; it keeps the HLT address.
- No register or flag write.

## Timing
- Reset, asynchronous, while `rst_n` = 0:
  - `pc` = 0, `ir_data` = 0, `cy` = 0, `zero` = 0, all registers = 0.
  - State = FETCH.
  - `imem_req` = 0, `halted` = 0, `wb_en` = 0, `wb_addr` = 0, `wb_data` = 0.
- First request: `imem_req` rises in the first cycle after `rst_n` deasserts.
- Zero-wait memory (`imem_valid` high in the same cycle as `imem_req`): every instruction takes exactly 3 cycles (FETCH, EXEC, WB).
- Each cycle with FETCH and `imem_valid` = 0 adds one cycle; `imem_addr` is stable throughout.
- `imem_valid` in EXEC, WB or HALT is ignored.
- A write is visible on the read ports in the FETCH that follows its WB, so back-to-back dependent instructions need no forwarding.
- Reset mid-instruction: the in-flight instruction is abandoned with no partial register or flag write. Execution restarts at pc 0.

## Test plan
- Arithmetic:
  - Stimulus: LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2 (DW=8).
  - Required: r3 = 0x10, `cy` = 1, `zero` = 0.
  - Required: `wb_en` pulses three times, 3 cycles apart.
- Subtract and branch:
  - Stimulus: LDI r1,5; SUB r2,r1,r1; JZ 0x10.
  - Required: r2 = 0, `zero` = 1, `cy` = 0.
  - Required: next `imem_addr` = 0x10.
  - Stimulus: SUB 3−5.
  - Required: result 0xFE, `cy` = 1.
- Shifts and counted loop:
  - Stimulus: SHL of 0x81.
  - Required: result 0x02, `cy` = 1.
  - Stimulus: SHR of 0x01.
  - Required: result 0, `zero` = 1, `cy` = 1.
  - Stimulus: decrement loop from 3 using JZ/JMP.
  - Required: exits after exactly 3 iterations.
- Wait states:
  - Stimulus: hold `imem_valid` low for 4 cycles on each fetch.
  - Required: architectural results identical to the zero-wait run.
  - Required: each instruction takes 7 cycles; `imem_addr` stable while waiting.
- Halt and wrap:
  - Stimulus: PCW=4, NOPs from address 0.
  - Required: pc wraps 15→0.
  - Stimulus: HLT at address 6.
  - Required: `halted` = 1, `imem_req` = 0, `pc` = 6, held for 20 cycles.
- Reset mid-op:
  - Stimulus: drop `rst_n` during the EXEC of an ADD.
  - Required: all outputs take their reset values immediately, no write to rd, fetch restarts at 0.
